// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   - arb_state_e      : arbiter FSM states
//   - DEF_NUM_REQ      : default requester count
//   - DEF_START_TIMEOUT: default cycles allowed for the transmitter to go busy
//   - DEF_GAP_CYCLES   : default idle cycles after each frame
package uart_pkg;

   localparam int DEF_NUM_REQ       = 4;
   localparam int DEF_START_TIMEOUT = 15;
   localparam int DEF_GAP_CYCLES    = 2;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LAUNCH     = 3'd1,
      WAIT_START = 3'd2,
      WAIT_DONE  = 3'd3,
      GAP        = 3'd4
   } arb_state_e;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Bundle between the requesters/transmitter and the arbiter.
//   req_valid/req_data/req_ready : per-requester byte handshake
//   uart_en/uart_din/uart_tx_busy: transmitter start pulse, byte, busy flag
//   grant_id/arb_busy/err_timeout: status
//   state_dbg                    : arbiter FSM state for observation
// Handshake: requester i holds req_valid[i] and its byte stable until it sees
// req_ready[i]=1 in the same cycle; that cycle is the transfer. req_ready is
// one-hot and lasts a single cycle. Dropping req_valid before the transfer is
// allowed and withdraws the request.
// Modports: master = arbiter side, slave = requester/transmitter side.
interface uart_tx_arb_if #(
   parameter int NUM_REQ = uart_pkg::DEF_NUM_REQ
);
   import uart_pkg::*;

   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 uart_en;
   logic [7:0]           uart_din;
   logic                 uart_tx_busy;
   logic [2:0]           grant_id;
   logic                 arb_busy;
   logic                 err_timeout;
   arb_state_e           state_dbg;

   modport master (
      input  req_valid, req_data, uart_tx_busy,
      output req_ready, uart_en, uart_din, grant_id, arb_busy, err_timeout,
             state_dbg
   );

   modport slave (
      output req_valid, req_data, uart_tx_busy,
      input  req_ready, uart_en, uart_din, grant_id, arb_busy, err_timeout,
             state_dbg
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
//   req     : request vector
//   pointer : index where the search starts (wraps past NUM_REQ-1 to 0)
//   grant   : one-hot winner, all zero when nothing is requested
//   index   : binary index of the winner
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [2:0]         pointer,
   output logic [NUM_REQ-1:0] grant,
   output logic [2:0]         index
);

   logic found;

   // Two passes instead of a modulo: first from pointer upward, then the
   // wrapped-around part below pointer.
   always_comb begin
      grant = '0;
      index = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[i] && (i >= int'(pointer))) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            index    = 3'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[i] && (i < int'(pointer))) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            index    = 3'(i);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates NUM_REQ byte requesters onto a single UART transmitter.
//   sys_clk : clock, rising edge
//   sys_rst : asynchronous active-high reset
//   bus     : uart_tx_arb_if master (requests, transmitter control, status)
// One byte is accepted in IDLE, launched with a one-cycle uart_en, then the
// FSM waits for the transmitter to go busy (bounded by START_TIMEOUT) and to
// go idle again, and finally idles GAP_CYCLES before the next grant.
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter int NUM_REQ       = DEF_NUM_REQ,
   parameter int START_TIMEOUT = DEF_START_TIMEOUT,
   parameter int GAP_CYCLES    = DEF_GAP_CYCLES
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   uart_tx_arb_if.master bus
);

   localparam int WW = $clog2(START_TIMEOUT + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   arb_state_e         state, state_nxt;
   logic [WW-1:0]      wcnt;
   logic [GW-1:0]      gcnt;
   logic [2:0]         rr_ptr;
   logic [2:0]         grant_idx;
   logic [2:0]         grant_id_q;
   logic [NUM_REQ-1:0] grant_vec;
   logic [NUM_REQ-1:0] req_ready_c;
   logic [7:0]         din_q;
   logic [7:0]         sel_data;
   logic               grant_fire;
   logic               timeout_hit;
   logic               err_q;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req     (bus.req_valid),
      .pointer (rr_ptr),
      .grant   (grant_vec),
      .index   (grant_idx)
   );

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_vec[i]) sel_data = bus.req_data[8*i +: 8];
      end
   end

   // Next state and per-cycle strobes. The grant is gated by sys_rst so no
   // acceptance pulse escapes while reset holds the FSM in IDLE.
   always_comb begin
      state_nxt   = state;
      grant_fire  = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (!sys_rst && (|bus.req_valid) && !bus.uart_tx_busy) begin
               grant_fire = 1'b1;
               state_nxt  = LAUNCH;
            end
         end
         LAUNCH: state_nxt = WAIT_START;
         WAIT_START: begin
            if (bus.uart_tx_busy) begin
               state_nxt = WAIT_DONE;
            end else if (wcnt == WW'(START_TIMEOUT)) begin
               timeout_hit = 1'b1;
               state_nxt   = GAP;
            end
         end
         WAIT_DONE: begin
            if (!bus.uart_tx_busy) state_nxt = GAP;
         end
         GAP: begin
            if (gcnt == GW'(GAP_CYCLES - 1)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign req_ready_c = grant_fire ? grant_vec : '0;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= IDLE;
         wcnt       <= '0;
         gcnt       <= '0;
         rr_ptr     <= '0;
         grant_id_q <= '0;
         din_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state <= state_nxt;
         // Registered so the pulse lands in the first GAP cycle.
         err_q <= timeout_hit;
         if (grant_fire) begin
            din_q      <= sel_data;
            grant_id_q <= grant_idx;
            rr_ptr     <= (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
         end
         // Counters clear outside their state and saturate inside it.
         if (state == WAIT_START) begin
            if (wcnt != WW'(START_TIMEOUT)) wcnt <= wcnt + 1'b1;
         end else begin
            wcnt <= '0;
         end
         if (state == GAP) begin
            if (gcnt != GW'(GAP_CYCLES)) gcnt <= gcnt + 1'b1;
         end else begin
            gcnt <= '0;
         end
      end
   end

   assign bus.req_ready   = req_ready_c;
   assign bus.uart_en     = (state == LAUNCH);
   assign bus.uart_din    = din_q;
   assign bus.grant_id    = grant_id_q;
   assign bus.arb_busy    = (state != IDLE);
   assign bus.err_timeout = err_q;
   assign bus.state_dbg   = state;

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;
   import uart_pkg::*;

   localparam int NR = 4;

   // ---------------- clock / reset ----------------
   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   always #5 sys_clk = ~sys_clk;

   uart_tx_arb_if #(.NUM_REQ(NR)) bus ();

   uart_tx_arb #(.NUM_REQ(NR), .START_TIMEOUT(15), .GAP_CYCLES(2)) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   // ---------------- transmitter model ----------------
   logic model_busy = 1'b0;
   logic ext_busy   = 1'b0;
   int   tx_mode    = 0;   // 0: answers uart_en, 1: never goes busy
   int   tx_hold    = 20;
   assign bus.uart_tx_busy = model_busy | ext_busy;

   initial forever begin
      @(negedge sys_clk);
      if (tx_mode == 0 && bus.uart_en === 1'b1 && !sys_rst) begin
         repeat (2) @(posedge sys_clk);
         #1 model_busy = 1'b1;
         repeat (tx_hold) @(posedge sys_clk);
         #1 model_busy = 1'b0;
      end
   end

   // ---------------- scoreboard state ----------------
   int checks   = 0;
   int failures = 0;
   logic [10:0] exp_q[$];          // {requester index, byte}
   logic [10:0] pend;
   logic        pend_valid = 1'b0;
   int ready_cnt = 0, en_cnt = 0, err_cnt = 0, cyc = 0, ws_entry = 0, gap_run = 0;
   arb_state_e prev_state = IDLE;
   logic prev_en  = 1'b0;
   logic prev_err = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge sys_clk) begin
      if (sys_rst) begin
         pend_valid = 1'b0;
         prev_state = IDLE;
         gap_run    = 0;
         prev_en    = 1'b0;
         prev_err   = 1'b0;
      end else begin
         cyc++;
         if (pend_valid) begin
            chk("uart_din", bus.uart_din, pend[7:0]);
            chk("grant_id", bus.grant_id, pend[10:8]);
            pend_valid = 1'b0;
         end
         if (bus.req_ready != '0) begin
            ready_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_grant actual=%b required=none", bus.req_ready);
            end else begin
               pend = exp_q.pop_front();
               chk("grant_onehot", bus.req_ready, 32'(1) << pend[10:8]);
               pend_valid = 1'b1;
            end
         end
         if (bus.uart_en) begin
            en_cnt++;
            chk("uart_en_state", bus.state_dbg, LAUNCH);
            chk("uart_en_width", prev_en, 0);
            chk("arb_busy_launch", bus.arb_busy, 1);
         end
         if (bus.state_dbg == WAIT_START && prev_state != WAIT_START) ws_entry = cyc;
         if (bus.err_timeout) begin
            err_cnt++;
            chk("timeout_delay", cyc - ws_entry, 16);
            chk("timeout_in_gap", bus.state_dbg, GAP);
            chk("err_width", prev_err, 0);
         end
         if (bus.state_dbg == GAP) begin
            gap_run++;
         end else if (prev_state == GAP) begin
            chk("gap_len", gap_run, 2);
            chk("gap_exit", bus.state_dbg, IDLE);
            gap_run = 0;
         end
         prev_state = bus.state_dbg;
         prev_en    = bus.uart_en;
         prev_err   = bus.err_timeout;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      sys_rst = 1'b1;
      bus.req_valid = '0;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      sys_rst = 1'b0;
   endtask

   task automatic wait_ready(input int target, input string name);
      int n = 0;
      while (ready_cnt < target && n < 400) begin
         @(negedge sys_clk);
         n++;
      end
      if (ready_cnt < target) begin
         checks++;
         failures++;
         $display("FAIL %s_grants actual=%0d required=%0d", name, ready_cnt, target);
      end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (!(bus.state_dbg == IDLE && model_busy == 1'b0 && exp_q.size() == 0 && !pend_valid)
             && n < 300) begin
         @(negedge sys_clk);
         n++;
      end
      if (n >= 300) begin
         checks++;
         failures++;
         $display("FAIL %s_idle actual=%0d required=%0d", name, bus.state_dbg, IDLE);
      end
      repeat (2) @(negedge sys_clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      int base, en0, err0, n;
      bus.req_valid = '0;
      bus.req_data  = '0;

      // Reset values, with all requests pending to show no grant leaks.
      bus.req_valid = 4'b1111;
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      chk("rst_uart_en", bus.uart_en, 0);
      chk("rst_uart_din", bus.uart_din, 0);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_grant_id", bus.grant_id, 0);
      chk("rst_arb_busy", bus.arb_busy, 0);
      chk("rst_err_timeout", bus.err_timeout, 0);
      chk("rst_state", bus.state_dbg, IDLE);
      do_reset();

      // Single requester, byte A5.
      tx_mode = 0; tx_hold = 20;
      bus.req_data = {8'h33, 8'h22, 8'h11, 8'hA5};
      en0 = en_cnt; err0 = err_cnt; base = ready_cnt;
      exp_q.push_back({3'd0, 8'hA5});
      bus.req_valid = 4'b0001;
      wait_ready(base + 1, "single");
      @(posedge sys_clk); #1 bus.req_valid = '0;
      wait_idle("single");
      chk("single_en_pulses", en_cnt - en0, 1);
      chk("single_no_timeout", err_cnt - err0, 0);

      // Round-robin over eight frames.
      do_reset();
      tx_hold = 4;
      bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      base = ready_cnt;
      for (int k = 0; k < 8; k++) exp_q.push_back({3'(k % 4), 8'h10 + 8'(k % 4)});
      bus.req_valid = 4'b1111;
      wait_ready(base + 8, "rr");
      @(posedge sys_clk); #1 bus.req_valid = '0;
      wait_idle("rr");

      // Fairness: 2, then 0 and 2 with requests 0101.
      do_reset();
      bus.req_data = {8'h43, 8'h42, 8'h41, 8'h40};
      base = ready_cnt;
      exp_q.push_back({3'd2, 8'h42});
      bus.req_valid = 4'b0100;
      wait_ready(base + 1, "fair_first");
      @(posedge sys_clk); #1;
      exp_q.push_back({3'd0, 8'h40});
      exp_q.push_back({3'd2, 8'h42});
      bus.req_valid = 4'b0101;
      wait_ready(base + 3, "fair");
      @(posedge sys_clk); #1 bus.req_valid = '0;
      wait_idle("fair");

      // Timeout: transmitter never goes busy; re-arbitration follows.
      do_reset();
      tx_mode = 1;
      bus.req_data = {8'h53, 8'h52, 8'h51, 8'h50};
      err0 = err_cnt; base = ready_cnt;
      exp_q.push_back({3'd0, 8'h50});
      bus.req_valid = 4'b0001;
      wait_ready(base + 1, "tmo_first");
      @(posedge sys_clk); #1;
      exp_q.push_back({3'd1, 8'h51});
      bus.req_valid = 4'b0010;
      wait_ready(base + 2, "tmo_rearb");
      @(posedge sys_clk); #1 bus.req_valid = '0;
      wait_idle("tmo");
      chk("timeout_count", err_cnt - err0, 2);
      tx_mode = 0;

      // Busy in IDLE blocks grants until it falls.
      do_reset();
      bus.req_data = {8'h63, 8'h62, 8'h61, 8'h60};
      ext_busy = 1'b1;
      bus.req_valid = 4'b0010;
      repeat (10) begin
         @(negedge sys_clk);
         chk("busy_idle_ready", bus.req_ready, 0);
         chk("busy_idle_arb_busy", bus.arb_busy, 0);
      end
      @(posedge sys_clk); #1;
      exp_q.push_back({3'd1, 8'h61});
      ext_busy = 1'b0;
      @(negedge sys_clk);
      chk("busy_release_grant", bus.req_ready, 4'b0010);
      @(posedge sys_clk); #1 bus.req_valid = '0;
      wait_idle("busy_idle");

      // Reset during WAIT_DONE.
      do_reset();
      tx_hold = 20;
      bus.req_data = {8'h73, 8'h72, 8'h71, 8'h70};
      err0 = err_cnt; base = ready_cnt;
      exp_q.push_back({3'd2, 8'h72});
      bus.req_valid = 4'b0100;
      wait_ready(base + 1, "mid_first");
      @(posedge sys_clk); #1 bus.req_valid = '0;
      n = 0;
      while (bus.state_dbg != WAIT_DONE && n < 50) begin
         @(negedge sys_clk);
         n++;
      end
      chk("mid_reach_wait_done", bus.state_dbg, WAIT_DONE);
      @(posedge sys_clk); #1;
      bus.req_valid = 4'b0101;
      sys_rst = 1'b1;
      #1;
      chk("mid_rst_uart_en", bus.uart_en, 0);
      chk("mid_rst_uart_din", bus.uart_din, 0);
      chk("mid_rst_req_ready", bus.req_ready, 0);
      chk("mid_rst_grant_id", bus.grant_id, 0);
      chk("mid_rst_arb_busy", bus.arb_busy, 0);
      chk("mid_rst_err", bus.err_timeout, 0);
      chk("mid_rst_state", bus.state_dbg, IDLE);
      exp_q.push_back({3'd0, 8'h70});
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      sys_rst = 1'b0;
      wait_ready(base + 2, "mid_after");
      @(posedge sys_clk); #1 bus.req_valid = '0;
      wait_idle("mid");
      chk("mid_no_timeout", err_cnt - err0, 0);

      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      failures++;
      $display("FAIL watchdog actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter START_TIMEOUT, default 15, maximum cycles allowed between the uart_en pulse and uart_tx_busy rising.
REQ-003 Parameter GAP_CYCLES, default 2, idle cycles inserted after each frame; minimum 1.
REQ-004 Port sys_clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 Port sys_rst, input, 1, asynchronous active-high reset.
REQ-006 Port req_valid, input, NUM_REQ, per-requester byte-pending flag.
REQ-007 Port req_data, input, 8*NUM_REQ, per-requester byte; requester i occupies bits [8i+7:8i].
REQ-008 Port req_ready, output, NUM_REQ, one-hot acceptance pulse.
REQ-009 Port uart_en, output, 1, transmitter start pulse.
REQ-010 Port uart_din, output, 8, byte presented to the transmitter.
REQ-011 Port uart_tx_busy, input, 1, transmitter busy flag.
REQ-012 Port grant_id, output, 3, index of the last accepted requester.
REQ-013 Port arb_busy, output, 1, high whenever the state is not IDLE.
REQ-014 Port err_timeout, output, 1, one-cycle pulse when a start attempt fails.

Function
REQ-015 The FSM shall have exactly five states: IDLE, LAUNCH, WAIT_START, WAIT_DONE and GAP.
REQ-016 In IDLE, when any req_valid bit is set and uart_tx_busy=0, the block shall grant exactly one requester i. In that same cycle it shall:
- pulse req_ready[i] high for 1 cycle;
- latch req_data[i] into uart_din;
- set grant_id=i;
- move to LAUNCH.
REQ-017 Arbitration shall be round-robin. The search starts at (last granted index + 1) mod NUM_REQ, and the pointer advances only on a grant.
REQ-018 In IDLE with uart_tx_busy=1, the block shall grant nothing and stay in IDLE.
REQ-019 uart_din shall hold its value from the grant until the next grant.
REQ-020 In LAUNCH, uart_en shall be 1 for exactly one cycle, then the FSM shall move to WAIT_START. uart_en shall be 0 in every other state.
REQ-021 WAIT_START shall count cycles from 0.
- When uart_tx_busy=1, the FSM shall move to WAIT_DONE.
- When the count reaches START_TIMEOUT with busy still 0, err_timeout shall pulse for 1 cycle and the FSM shall go to GAP.
REQ-022 In WAIT_DONE, when uart_tx_busy=0, the FSM shall move to GAP. There is no timeout in this state.
REQ-023 GAP shall last GAP_CYCLES cycles and then return to IDLE. This guarantees that uart_en stays low long enough for a fresh rising edge.
REQ-024 A requester dropping req_valid while not granted shall have no effect.
- Requests shall not be queued; the block holds at most one byte.
REQ-025 Widths: the WAIT_START counter shall be $clog2(START_TIMEOUT+1) bits and the GAP counter $clog2(GAP_CYCLES+1) bits. Both shall saturate and never wrap.

Reset
REQ-026 On sys_rst=1, asynchronously and regardless of FSM state, all of the following shall hold:
- state=IDLE;
- uart_en=0, uart_din=0, req_ready=0, grant_id=0, arb_busy=0, err_timeout=0;
- the round-robin pointer shall select requester 0 first.
REQ-027 Reset asserted mid-frame shall abandon the frame; no req_ready or err_timeout pulse shall be produced afterwards for that frame.

Structure
REQ-028 The following shall live in the shared package uart_pkg:
- the FSM state enum;
- the default timeout and gap constants.
REQ-029 Round-robin selection shall be the sub-module rr_arbiter, with inputs req and pointer, and outputs one-hot grant and index. It shall be purely combinational; the pointer register stays in uart_tx_arb.

Verification
REQ-030 Single requester: req_valid=4'b0001, data 8'hA5; a transmitter model raises busy 2 cycles after uart_en and holds it 20 cycles.
- req_ready[0] shall pulse once and uart_din shall be 8'hA5.
- uart_en shall pulse once, and the FSM shall return to IDLE exactly GAP_CYCLES=2 cycles after busy falls.
REQ-031 Round-robin: req_valid=4'b1111 held high for 8 frames; the grant order shall be 0,1,2,3,0,1,2,3.
REQ-032 Fairness: requester 2 is granted, then req_valid=4'b0101; the next grant shall be requester 0, then requester 2.
REQ-033 Timeout: busy is never raised; err_timeout shall pulse exactly 16 cycles after the WAIT_START entry, the FSM shall pass through GAP, and it shall then re-arbitrate.
REQ-034 Busy in IDLE: uart_tx_busy=1 externally with req_valid=4'b0010; there shall be no req_ready pulse until busy falls, then requester 1 shall be granted the next cycle.
REQ-035 Mid-frame reset: sys_rst is pulsed during WAIT_DONE; all outputs shall be at reset values in the same cycle, and the next grant shall be requester 0.
